// File: rtl/seq_det_pkg.sv
// Shared definitions for the multi-pattern Mealy sequence detector.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package seq_det_pkg;

  localparam logic [1:0] MODE_OVERLAP = 2'd0;
  localparam logic [1:0] MODE_NONOVL  = 2'd1;
  localparam logic [1:0] MODE_FRAMED  = 2'd2;

  // Detection policy currently applied by the top level. Mode input value 3
  // decodes to ST_FRAMED as well.
  typedef enum logic [1:0] {
    ST_OVERLAP,
    ST_NONOVL,
    ST_FRAMED
  } mode_state_e;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_pat_cmp.sv
// One programmable pattern slot: pattern register plus enable-qualified compare.
// Latency: hit_o is combinational; a load lands on the next posedge.
// Backpressure: none; the compare is qualified by cmp_vld_i from the top level.
//
// Ports:
//   clk, rst_n  clock / async active-low reset (clears the pattern to 0)
//   load_i      write pat_q with data_i on posedge
//   data_i      new pattern value, MSB = first bit received
//   en_i        slot enable; a disabled slot never hits
//   cmp_vld_i   valid input bit and full history
//   word_i      {history, current bit}
//   hit_o       slot match in the current cycle
module seq_pat_cmp #(
  parameter int PAT_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [PAT_LEN-1:0] data_i,
  input  logic               en_i,
  input  logic               cmp_vld_i,
  input  logic [PAT_LEN-1:0] word_i,
  output logic               hit_o
);

  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] pat_d;

  always_comb begin
    pat_d = pat_q;
    if (load_i) pat_d = data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pat_q <= '0;
    else        pat_q <= pat_d;
  end

  // Compares against the registered value, so a load in the same cycle
  // does not affect this cycle's hit.
  assign hit_o = cmp_vld_i & en_i & (word_i == pat_q);

endmodule

// File: rtl/mealy_multi_seq_detector.sv
// Mealy detector for N_PAT programmable PAT_LEN-bit patterns on a serial stream.
// Latency: zero; dec/hit_vec assert in the cycle the last pattern bit is present.
// Backpressure: none; in_valid low freezes history and fill and masks all hits.
//
// Ports:
//   clk, rst_n  clock / async active-low reset
//   in_valid    qualifies in
//   in          serial data bit
//   mode        0 overlap, 1 non-overlap, 2/3 framed
//   pat_en      per-slot enable
//   pat_load    pattern write strobe; pat_idx selects slot, pat_data is the value
//   cnt_clr     synchronous clear of hit_cnt (wins over a same-cycle hit)
//   dec         OR of hit_vec
//   hit_vec     per-slot match this cycle
//   hit_cnt     saturating count of cycles with dec=1
module mealy_multi_seq_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int N_PAT   = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in,
  input  logic [1:0]         mode,
  input  logic [N_PAT-1:0]   pat_en,
  input  logic               pat_load,
  input  logic [2:0]         pat_idx,
  input  logic [PAT_LEN-1:0] pat_data,
  input  logic               cnt_clr,
  output logic               dec,
  output logic [N_PAT-1:0]   hit_vec,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam int HIST_W = PAT_LEN - 1;
  localparam int FILL_W = clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  mode_state_e        mode_q, mode_d;

  logic [PAT_LEN-1:0] word;
  logic               fill_full;
  logic               cmp_vld;
  logic               enter_framed;

  assign word      = {hist_q, in};
  assign fill_full = (fill_q == FILL_MAX);
  assign cmp_vld   = in_valid & fill_full;

  for (genvar g = 0; g < N_PAT; g++) begin : g_slot
    seq_pat_cmp #(
      .PAT_LEN(PAT_LEN)
    ) u_cmp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (pat_load && (pat_idx == 3'(g))),
      .data_i   (pat_data),
      .en_i     (pat_en[g]),
      .cmp_vld_i(cmp_vld),
      .word_i   (word),
      .hit_o    (hit_vec[g])
    );
  end

  assign dec = |hit_vec;

  // Mode FSM: tracks the applied policy so that entry into framed mode can
  // be detected and the frame counter restarted.
  always_comb begin
    mode_d = mode_q;
    case (mode)
      MODE_OVERLAP: mode_d = ST_OVERLAP;
      MODE_NONOVL:  mode_d = ST_NONOVL;
      default:      mode_d = ST_FRAMED;
    endcase
  end

  assign enter_framed = (mode_d == ST_FRAMED) && (mode_q != ST_FRAMED);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (in_valid) begin
      hist_d = word[HIST_W-1:0];
      case (mode_d)
        ST_NONOVL: begin
          // A hit consumes its bits; the next match needs PAT_LEN fresh bits.
          if (dec)            fill_d = '0;
          else if (!fill_full) fill_d = fill_q + FILL_W'(1);
        end
        ST_FRAMED: begin
          // Every PAT_LEN-th valid bit closes a frame, hit or not.
          if (fill_full) fill_d = '0;
          else           fill_d = fill_q + FILL_W'(1);
        end
        default: begin
          if (!fill_full) fill_d = fill_q + FILL_W'(1);
        end
      endcase
    end
    // The first frame begins with the next valid bit after entering framed
    // mode, regardless of what was already in the history.
    if (enter_framed) fill_d = '0;
  end

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (cnt_clr)                        hit_cnt_d = '0;
    else if (dec && hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      hit_cnt_q <= '0;
      mode_q    <= ST_OVERLAP;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      hit_cnt_q <= hit_cnt_d;
      mode_q    <= mode_d;
    end
  end

  assign hit_cnt = hit_cnt_q;

endmodule
